// File: rtl/led_arbiter.sv
// Round-robin time-sliced arbiter that shares one LED bank between NUM_REQ pattern sources.
// Optional all-off gap between owners is compiled in with LED_ARB_BLANK_EN.
//
// state | meaning
// IDLE  | no owner; pick the next requester after last_owner
// OWN   | last_owner holds the grant; led follows its pattern
// BLANK | LEDs dark for BLANK_CYCLES before re-arbitrating (LED_ARB_BLANK_EN only)
module led_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LED_WIDTH    = 8,
    parameter int SLICE_CYCLES = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LED_WIDTH-1:0]   led_in,
    output logic [NUM_REQ-1:0]             grant,
    output logic [LED_WIDTH-1:0]           led,
    output logic                           busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(SLICE_CYCLES);

    if (NUM_REQ < 2 || NUM_REQ > 8 || SLICE_CYCLES < 2 || BLANK_CYCLES < 1) begin : g_param_check
        $error("led_arbiter: illegal parameter set");
    end

`ifdef LED_ARB_BLANK_EN
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;
    logic [BW-1:0] blank_cnt;
`else
    typedef enum logic [1:0] {IDLE, OWN} state_t;
`endif

    state_t               state;
    logic [IW-1:0]        last_owner;   // doubles as the current owner while in OWN
    logic [CW-1:0]        slice_cnt;
    logic [IW-1:0]        pick;
    logic                 found;
    logic [LED_WIDTH-1:0] owner_led;
    logic                 owner_req;
    logic                 others_req;
    logic                 slice_done;
    logic                 release_now;

    always_comb begin
        pick  = last_owner;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = int'(last_owner) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[IW'(idx)]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        owner_led = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (last_owner == IW'(i)) owner_led = led_in[i*LED_WIDTH +: LED_WIDTH];
        end
    end

    // grant is one-hot of the owner while in OWN, so it masks req directly
    assign owner_req   = |(req & grant);
    assign others_req  = |(req & ~grant);
    assign slice_done  = (slice_cnt == CW'(SLICE_CYCLES - 1));
    assign release_now = !owner_req || (slice_done && others_req);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= '0;
            led        <= '0;
            busy       <= 1'b0;
            last_owner <= IW'(NUM_REQ - 1);
            slice_cnt  <= '0;
`ifdef LED_ARB_BLANK_EN
            blank_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        last_owner <= pick;
                        grant      <= NUM_REQ'(1) << pick;
                        busy       <= 1'b1;
                        slice_cnt  <= '0;
                        state      <= OWN;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                OWN: begin
                    led <= owner_led;
                    if (!slice_done) slice_cnt <= slice_cnt + CW'(1);
                    if (release_now) begin
                        grant <= '0;
                        busy  <= 1'b0;
`ifdef LED_ARB_BLANK_EN
                        led       <= '0;
                        blank_cnt <= BW'(BLANK_CYCLES - 1);
                        state     <= BLANK;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef LED_ARB_BLANK_EN
                BLANK: begin
                    if (blank_cnt == '0) state <= IDLE;
                    else                 blank_cnt <= blank_cnt - BW'(1);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter: directed scenarios plus randomized traffic, all checked by a
// cycle scoreboard fed from a behavioural reference model.
module tb_led_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SLICE = 16;
    localparam int BLANK = 4;
`ifdef LED_ARB_BLANK_EN
    localparam int GAP      = BLANK + 1;
    localparam bit BLANK_ON = 1'b1;
`else
    localparam int GAP      = 1;
    localparam bit BLANK_ON = 1'b0;
`endif

    logic           clk;
    logic           resetn;
    logic [N-1:0]   req;
    logic [N*W-1:0] led_in;
    logic [N-1:0]   grant;
    logic [W-1:0]   led;
    logic           busy;

    int passed = 0;
    int total  = 0;

    led_arbiter #(.NUM_REQ(N), .LED_WIDTH(W), .SLICE_CYCLES(SLICE), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .resetn(resetn), .req(req), .led_in(led_in),
        .grant(grant), .led(led), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] l;
        logic         b;
    } obs_t;

    obs_t q[$];

    // reference model: owner index, cycles held so far, remaining dark cycles
    int           m_state;   // 0 idle, 1 owning, 2 dark gap
    int           m_owner;
    int           m_held;
    int           m_blank;
    logic [N-1:0] m_grant;
    logic [W-1:0] m_led;

    task automatic model_step();
        bit others;
        case (m_state)
            0: begin
                m_grant = '0;
                if (req != 0) begin
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_owner + k) % N;
                        if (req[c]) begin
                            m_owner = c;
                            m_held  = 1;
                            m_state = 1;
                            m_grant = N'(1) << c;
                            break;
                        end
                    end
                end
            end
            1: begin
                m_led  = led_in[m_owner*W +: W];
                others = (req & ~(N'(1) << m_owner)) != 0;
                if (!req[m_owner] || (m_held >= SLICE && others)) begin
                    m_grant = '0;
                    if (BLANK_ON) begin
                        m_led   = '0;
                        m_blank = BLANK;
                        m_state = 2;
                    end else begin
                        m_state = 0;
                    end
                end else begin
                    m_held++;
                end
            end
            default: begin
                m_blank--;
                if (m_blank == 0) m_state = 0;
            end
        endcase
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_state = 0;
            m_owner = N - 1;
            m_held  = 0;
            m_blank = 0;
            m_grant = '0;
            m_led   = '0;
            q.delete();
        end else begin
            model_step();
        end
        if (clk === 1'b1) q.push_back({m_grant, m_led, (m_grant != 0)});
    end

    always @(negedge clk) begin
        obs_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            total++;
            if ({grant, led, busy} === e) passed++;
            else $display("FAIL scoreboard t=%0t got grant=%b led=%h busy=%b expected grant=%b led=%h busy=%b",
                          $time, grant, led, busy, e.g, e.l, e.b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] v);
        led_in[i*W +: W] = v;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        #2 resetn = 1'b0;
        req = r;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
    endtask

    task automatic wait_grant(input logic [N-1:0] exp, input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant === exp) break;
        end
        chk(name, grant, exp);
    endtask

    logic [N-1:0] g[96];
    int           idx, len1, gap1, len2, gap2;
    logic [N-1:0] v1, v2, v3;

    initial begin
        resetn = 1'b1;
        req    = '0;
        led_in = '0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        #2 resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_grant", grant, 0);
        chk("idle_led", led, 0);
        chk("idle_busy", busy, 0);

        // sole requester
        set_lane(0, 8'hA5);
        req = 4'b0001;
        @(negedge clk);
        chk("sole_grant", grant, 4'b0001);
        chk("sole_busy", busy, 1);
        @(negedge clk);
        chk("sole_led", led, 8'hA5);
        repeat (110) @(negedge clk);
        chk("sole_hold", grant, 4'b0001);

        // two contenders from reset
        do_reset(4'b0011);
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            g[i] = grant;
        end
        idx = 0;
        while (idx < 95 && g[idx] == 0) idx++;
        v1 = g[idx];
        len1 = 0; while (idx < 95 && g[idx] == v1) begin len1++; idx++; end
        gap1 = 0; while (idx < 95 && g[idx] == 0)  begin gap1++; idx++; end
        v2 = g[idx];
        len2 = 0; while (idx < 95 && g[idx] == v2) begin len2++; idx++; end
        gap2 = 0; while (idx < 95 && g[idx] == 0)  begin gap2++; idx++; end
        v3 = g[idx];
        chk("cont_owner1", v1, 4'b0001);
        chk("cont_len1", len1, SLICE);
        chk("cont_gap1", gap1, GAP);
        chk("cont_owner2", v2, 4'b0010);
        chk("cont_len2", len2, SLICE);
        chk("cont_gap2", gap2, GAP);
        chk("cont_owner3", v3, 4'b0001);

        // owner 2 drops after three granted cycles
        do_reset(4'b0000);
        set_lane(2, 8'h3C);
        req = 4'b0100;
        wait_grant(4'b0100, "drop_wait");
        repeat (2) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        chk("drop_grant", grant, 0);
        chk("drop_busy", busy, 0);
        chk("drop_led", led, BLANK_ON ? 32'h0 : 32'h3C);

        // asynchronous reset in the middle of a grant
        req = 4'b0100;
        wait_grant(4'b0100, "mid_wait");
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_led", led, 0);
        chk("mid_rst_busy", busy, 0);
        req = 4'b1111;
        @(negedge clk);
        #2 resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant !== 0) break;
        end
        chk("post_rst_first", grant, 4'b0001);

        // randomized traffic with occasional short reset pulses
        do_reset(4'b0000);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            led_in = $urandom;
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                #1 resetn = 1'b0;
                #2 resetn = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
